// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//   Captures a binary value and converts it to BCD one bit per clock using
//   shift-add-3. It then time-multiplexes DIGITS common-anode 7-segment digits
//   from a free-running scan counter. The number is shown only while halt=1.
//   Otherwise every digit shows a dash.
//
// Ports
//   clk    in   1       system clock, rising edge
//   rst_n  in   1       asynchronous active-low reset
//   value  in   DATA_W  binary value to display
//   load   in   1       capture strobe for value, ignored while busy=1
//   halt   in   1       1: show number, 0: dash on every digit
//   seg    out  7       segments {a,b,c,d,e,f,g}, active-low, registered
//   an     out  DIGITS  digit enables, active-low one-hot, registered
//   busy   out  1       BCD conversion in progress
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
   parameter int DIGITS     = 4,
   parameter int DATA_W     = 14,
   parameter int SCAN_DIV   = 50000,
   parameter int LEAD_BLANK = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] value,
   input  logic              load,
   input  logic              halt,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an,
   output logic              busy
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam int BCD_W = 4 * DIGITS;
   localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS - 1);

   localparam logic [6:0] SEG_DASH  = 7'b1111110;
   localparam logic [6:0] SEG_ERR   = 7'b0110000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic {IDLE, CONV} state_t;

   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic [BCD_W-1:0]  acc;
   logic [BCD_W-1:0]  acc_next;
   logic [BCD_W-1:0]  disp;
   logic [BIT_W-1:0]  bit_cnt;
   logic              ovf;

   logic [CNT_W-1:0]  scan_cnt;
   logic [IDX_W-1:0]  idx;
   logic [3:0]        nibble;
   logic [BCD_W-1:0]  upper;
   logic [6:0]        seg_next;

   // Every BCD nibble that is 5 or more gets 3 added before the shift. That
   // way a nibble which reaches 10 after the doubling carries into the next
   // nibble.
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] a);
      logic [BCD_W-1:0] r;
      r = a;
      for (int i = 0; i < DIGITS; i++)
         if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      return r;
   endfunction

   function automatic logic [6:0] dec7(input logic [3:0] d);
      case (d)
         4'd0:    dec7 = 7'b0000001;
         4'd1:    dec7 = 7'b1001111;
         4'd2:    dec7 = 7'b0010010;
         4'd3:    dec7 = 7'b0000110;
         4'd4:    dec7 = 7'b1001100;
         4'd5:    dec7 = 7'b0100100;
         4'd6:    dec7 = 7'b0100000;
         4'd7:    dec7 = 7'b0001111;
         4'd8:    dec7 = 7'b0000000;
         4'd9:    dec7 = 7'b0001100;
         default: dec7 = SEG_BLANK;
      endcase
   endfunction

   always_comb begin
      logic [BCD_W-1:0] adj;
      adj      = add3(acc);
      acc_next = {adj[BCD_W-2:0], shreg[DATA_W-1]};
   end

   // Conversion FSM. busy is held in its own flop so the port is registered.
   // The display register must start at zero, so it is reset with the rest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         shreg   <= '0;
         acc     <= '0;
         bit_cnt <= '0;
         disp    <= '0;
         ovf     <= 1'b0;
         busy    <= 1'b0;
      end else begin
         // NOTE: state flops use non-blocking assignments so every register
         // samples values from before the edge, whatever the statement order.
         case (state)
            IDLE: begin
               if (load) begin
                  shreg   <= value;
                  acc     <= '0;
                  bit_cnt <= '0;
                  ovf     <= 64'(value) > MAX_VAL;
                  busy    <= 1'b1;
                  state   <= CONV;
               end
            end
            CONV: begin
               shreg   <= shreg << 1;
               acc     <= acc_next;
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                  disp  <= acc_next;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Segment pattern for the digit the scan index points at.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      seg_next = SEG_BLANK;
      nibble   = disp[{idx, 2'b00} +: 4];
      upper    = disp >> {idx, 2'b00};
      if (!halt)
         seg_next = SEG_DASH;
      else if (ovf)
         seg_next = SEG_ERR;
      else if (LEAD_BLANK != 0 && idx != '0 && upper == '0)
         seg_next = SEG_BLANK;
      else
         seg_next = dec7(nibble);
   end

   // Scan timing. an and seg are both derived from idx in the same edge, so
   // only one digit is ever enabled and it always carries its own pattern.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         idx      <= '0;
         seg      <= SEG_BLANK;
         an       <= '1;
      end else begin
         if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         an  <= ~(DIGITS'(1) << idx);
         seg <= seg_next;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//   Scoreboarded bench for display_scan_ctrl (DIGITS=4, DATA_W=14, SCAN_DIV=4).
//   The stimulus process loads values and pushes the expected digit frames.
//   A monitor pops one entry at each digit-slot change and compares it.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

   localparam int DIGITS     = 4;
   localparam int DATA_W     = 14;
   localparam int SCAN_DIV   = 4;
   localparam int LEAD_BLANK = 1;

   logic              clk;
   logic              rst_n;
   logic [DATA_W-1:0] value;
   logic              load;
   logic              halt;
   logic [6:0]        seg;
   logic [DIGITS-1:0] an;
   logic              busy;

   typedef struct {
      logic [DIGITS-1:0] an;
      logic [6:0]        seg;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0001100};

   display_scan_ctrl #(
      .DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV), .LEAD_BLANK(LEAD_BLANK)
   ) dut (
      .clk(clk), .rst_n(rst_n), .value(value), .load(load),
      .halt(halt), .seg(seg), .an(an), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the pattern digit d should show for a given value and halt.
   function automatic logic [6:0] model_seg(input int v, input bit h, input int d);
      int pow;
      pow = 1;
      for (int i = 0; i < d; i++) pow = pow * 10;
      if (!h)                      return 7'b1111110;
      if (v > 9999)                return 7'b0110000;
      if (LEAD_BLANK != 0 && d > 0 && v < pow) return 7'b1111111;
      return seg_tab[(v / pow) % 10];
   endfunction

   // Monitor: one comparison per digit-slot change while expectations are queued.
   initial begin
      logic [DIGITS-1:0] prev_an;
      int                slot_len;
      exp_t              e;
      prev_an  = '1;
      slot_len = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            slot_len = 0;
         end else begin
            check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
            if (an != prev_an) begin
               if (q.size() > 0) begin
                  e = q.pop_front();
                  check("scan_an", 32'(an), 32'(e.an));
                  check("scan_seg", 32'(seg), 32'(e.seg));
                  check("slot_len", 32'(slot_len), 32'(SCAN_DIV));
               end
               slot_len = 1;
            end else begin
               slot_len++;
            end
         end
         prev_an = an;
      end
   end

   // Wait for the last digit slot, then queue one full frame starting at digit 0.
   task automatic expect_frame(input int v, input bit h);
      int guard;
      guard = 0;
      while (an != 4'b0111 && guard < 64) begin
         @(negedge clk);
         guard++;
      end
      check("frame_align_timeout", 32'(an == 4'b0111), 32'd1);
      @(posedge clk);
      #1;
      for (int d = 0; d < DIGITS; d++) begin
         exp_t e;
         e.an  = ~(DIGITS'(1) << d);
         e.seg = model_seg(v, h, d);
         q.push_back(e);
      end
      guard = 0;
      while (q.size() > 0 && guard < 64) begin
         @(negedge clk);
         guard++;
      end
      check("frame_drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
   endtask

   // Pulse load and measure busy. inj >= 0 issues a second load mid-conversion.
   task automatic load_value(input int v, input int inj);
      int len;
      @(negedge clk);
      value = DATA_W'(v);
      load  = 1'b1;
      @(negedge clk);
      load = 1'b0;
      len  = 0;
      while (busy && len < 100) begin
         len++;
         if (len == 5 && inj >= 0) begin
            value = DATA_W'(inj);
            load  = 1'b1;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
      end
      load = 1'b0;
      check("busy_len", 32'(len), 32'(DATA_W));
      @(negedge clk);
      check("busy_stays_low", 32'(busy), 32'd0);
   endtask

   initial begin
      int v;
      bit h;
      rst_n = 1'b0;
      load  = 1'b0;
      halt  = 1'b1;
      value = '0;
      repeat (3) @(negedge clk);
      check("rst_seg", 32'(seg), 32'h7f);
      check("rst_an", 32'(an), 32'hf);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;

      // Asynchronous reset mid-scan.
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_seg", 32'(seg), 32'h7f);
      check("async_rst_an", 32'(an), 32'hf);
      check("async_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Display register is zero after reset: a single '0'.
      expect_frame(0, 1'b1);

      load_value(1234, -1);
      expect_frame(1234, 1'b1);
      load_value(7, -1);
      expect_frame(7, 1'b1);
      load_value(0, -1);
      expect_frame(0, 1'b1);
      load_value(10000, -1);
      expect_frame(10000, 1'b1);
      @(negedge clk);
      halt = 1'b0;
      expect_frame(10000, 1'b0);
      @(negedge clk);
      halt = 1'b1;

      // A load while busy is dropped.
      load_value(1234, 42);
      expect_frame(1234, 1'b1);

      // Reset during conversion aborts it without committing.
      @(negedge clk);
      value = DATA_W'(5678);
      load  = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("conv_rst_busy", 32'(busy), 32'd0);
      check("conv_rst_an", 32'(an), 32'hf);
      check("conv_rst_seg", 32'(seg), 32'h7f);
      @(negedge clk);
      rst_n = 1'b1;
      expect_frame(0, 1'b1);
      load_value(5678, -1);
      expect_frame(5678, 1'b1);

      // Randomised values, including some overflow values and halt=0 frames.
      for (int n = 0; n < 12; n++) begin
         if ($urandom_range(0, 3) == 0) v = int'($urandom_range(10000, 16383));
         else                           v = int'($urandom_range(0, 9999));
         h = ($urandom_range(0, 4) != 0);
         load_value(v, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 16383)) : -1);
         @(negedge clk);
         halt = h;
         expect_frame(v, h);
         halt = 1'b1;
      end

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
